ac97_codec_link: RTL and testbench



---
 rtl/ac97_pkg.sv | 56 +++++
 rtl/ac97_slot_ser.sv | 63 ++++++
 rtl/ac97_codec_link.sv | 179 +++++++++++++++++
 tb/tb_ac97_codec_link.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
//------------------------------------------------------------------------------
// Module      : ac97_pkg
// Description : AC-link frame geometry, tag bit positions, FSM encodings and
//               the transmit content record shared by the codec link blocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ac97_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int TAG_BITS    = 16;
    localparam int SLOT_BITS   = 20;
    localparam int SAMPLE_BITS = 16;
    localparam int CNT_W       = 8;

    localparam int SLOT1_START = TAG_BITS;
    localparam int SLOT2_START = SLOT1_START + SLOT_BITS;
    localparam int SLOT3_START = SLOT2_START + SLOT_BITS;
    localparam int SLOT4_START = SLOT3_START + SLOT_BITS;
    localparam int SLOT5_START = SLOT4_START + SLOT_BITS;

    localparam int TAG_READY = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    typedef logic [CNT_W-1:0] bit_idx_t;

    // Decode happens on the last bit of a slot pair so strobes land one cycle later
    localparam bit_idx_t TAG_DONE_BIT    = bit_idx_t'(TAG_BITS - 1);
    localparam bit_idx_t CMD_DECODE_BIT  = bit_idx_t'(SLOT3_START - 1);
    localparam bit_idx_t PLAY_DECODE_BIT = bit_idx_t'(SLOT5_START - 1);
    localparam bit_idx_t LAST_BIT        = bit_idx_t'(FRAME_BITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FRAME = 1'b1;

    typedef struct packed {
        logic                   ready;
        logic                   stat_valid;
        logic [6:0]             stat_addr;
        logic [SAMPLE_BITS-1:0] stat_data;
        logic                   cap_valid;
        logic [SAMPLE_BITS-1:0] cap_left;
        logic [SAMPLE_BITS-1:0] cap_right;
    } tx_content_t;

    function automatic logic [SLOT_BITS-1:0] slot_of(input logic [SAMPLE_BITS-1:0] sample);
        return {sample, 4'b0000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ac97_slot_ser.sv
//------------------------------------------------------------------------------
// Module      : ac97_slot_ser
// Description : Builds the 256-bit SDATA_IN frame at bit 0 and shifts it out
//               MSB first with a registered output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ac97_slot_ser
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_active,
    input  tx_content_t i_content,
    output logic        o_sdata
);

    localparam int c_TAIL_BITS = FRAME_BITS - TAG_BITS - 4 * SLOT_BITS;

    logic [TAG_BITS-1:0]   w_tag;
    logic [SLOT_BITS-1:0]  w_slot1;
    logic [SLOT_BITS-1:0]  w_slot2;
    logic [SLOT_BITS-1:0]  w_slot3;
    logic [SLOT_BITS-1:0]  w_slot4;
    logic [FRAME_BITS-1:0] w_frame;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_sdata;

    always_comb begin
        w_tag   = {i_content.ready,
                   i_content.stat_valid, i_content.stat_valid,
                   i_content.cap_valid,  i_content.cap_valid,
                   11'b0};
        w_slot1 = i_content.stat_valid ? {1'b0, i_content.stat_addr, 12'b0} : '0;
        w_slot2 = i_content.stat_valid ? slot_of(i_content.stat_data) : '0;
        w_slot3 = i_content.cap_valid  ? slot_of(i_content.cap_left)  : '0;
        w_slot4 = i_content.cap_valid  ? slot_of(i_content.cap_right) : '0;
        w_frame = {w_tag, w_slot1, w_slot2, w_slot3, w_slot4, {c_TAIL_BITS{1'b0}}};
    end

    // Bit 0 goes straight from the built frame; the rest follow from the shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_sdata <= 1'b0;
        end else if (i_load) begin
            r_sdata <= w_frame[FRAME_BITS-1];
            r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
        end else if (i_active) begin
            r_sdata <= r_shift[FRAME_BITS-1];
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end else begin
            r_sdata <= 1'b0;
        end
    end

    assign o_sdata = r_sdata;

endmodule

`default_nettype wire

// File: rtl/ac97_codec_link.sv
//------------------------------------------------------------------------------
// Module      : ac97_codec_link
// Description : Codec-side AC-link engine: SYNC lock, SDATA_OUT slot decode,
//               read status and capture return on SDATA_IN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ac97_codec_link
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        AC97_SYNC,
    input  logic        AC97_SDATA_OUT,
    output logic        AC97_SDATA_IN,
    input  logic        codec_ready,
    output logic        cmd_valid,
    output logic        cmd_rd,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic [15:0] reg_rd_data,
    output logic        play_valid,
    output logic [15:0] play_left,
    output logic [15:0] play_right,
    input  logic        rec_valid,
    input  logic [15:0] rec_left,
    input  logic [15:0] rec_right,
    output logic        rec_overrun,
    output logic        resync_err
);

    localparam int c_RX_W = 2 * SLOT_BITS;

    logic                     r_sync_q;
    logic                     r_sync_armed;
    logic [0:0]               r_state;
    bit_idx_t                 r_cnt;
    logic [c_RX_W-2:0]        r_rx_sh;
    logic [TAG_READY:TAG_SLOT4] r_tag;

    logic                     r_stat_valid;
    logic [6:0]               r_stat_addr;
    logic [15:0]              r_stat_data;
    logic                     r_pend;
    logic [15:0]              r_pend_left;
    logic [15:0]              r_pend_right;

    logic                     w_sync_rise;
    logic                     w_in_frame;
    bit_idx_t                 w_bit;
    logic [c_RX_W-1:0]        w_rx_next;
    logic [SLOT_BITS-1:0]     w_rx_hi;
    logic [SLOT_BITS-1:0]     w_rx_lo;
    logic                     w_unused_rx;
    tx_content_t              w_tx;

    // The arm flag keeps a SYNC that is already high at reset release from counting as a rise
    assign w_sync_rise = AC97_SYNC && !r_sync_q && r_sync_armed;
    assign w_in_frame  = w_sync_rise || (r_state == FRAME);
    assign w_bit       = w_sync_rise ? '0 : r_cnt;
    assign w_rx_next   = {r_rx_sh, AC97_SDATA_OUT};
    assign w_rx_hi     = w_rx_next[c_RX_W-1 -: SLOT_BITS];
    assign w_rx_lo     = w_rx_next[SLOT_BITS-1:0];
    assign w_unused_rx = &{1'b0, w_rx_hi[3:0], w_rx_lo[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q     <= 1'b0;
            r_sync_armed <= !AC97_SYNC;
            r_state      <= IDLE;
            r_cnt        <= '0;
            resync_err   <= 1'b0;
        end else begin
            r_sync_q   <= AC97_SYNC;
            resync_err <= w_sync_rise && (r_state == FRAME) && (r_cnt != LAST_BIT);
            if (!AC97_SYNC) begin
                r_sync_armed <= 1'b1;
            end
            if (w_sync_rise) begin
                r_state <= FRAME;
                r_cnt   <= bit_idx_t'(1);
            end else if (r_state == FRAME) begin
                if (r_cnt == LAST_BIT) begin
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + bit_idx_t'(1);
                end
            end
        end
    end

    // Slot pairs are decoded from the shift register plus the bit arriving this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sh    <= '0;
            r_tag      <= '0;
            cmd_valid  <= 1'b0;
            cmd_rd     <= 1'b0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
            play_valid <= 1'b0;
            play_left  <= '0;
            play_right <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            play_valid <= 1'b0;
            if (w_in_frame) begin
                r_rx_sh <= w_rx_next[c_RX_W-2:0];
                if (w_bit == TAG_DONE_BIT) begin
                    r_tag <= w_rx_next[TAG_READY:TAG_SLOT4];
                end
                if (w_bit == CMD_DECODE_BIT && r_tag[TAG_READY] && r_tag[TAG_SLOT1]) begin
                    cmd_valid <= 1'b1;
                    cmd_rd    <= w_rx_hi[19];
                    cmd_addr  <= w_rx_hi[18:12];
                    cmd_data  <= r_tag[TAG_SLOT2] ? w_rx_lo[19:4] : '0;
                end
                if (w_bit == PLAY_DECODE_BIT && r_tag[TAG_SLOT3] && r_tag[TAG_SLOT4]) begin
                    play_valid <= 1'b1;
                    play_left  <= w_rx_hi[19:4];
                    play_right <= w_rx_lo[19:4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_valid <= 1'b0;
            r_stat_addr  <= '0;
            r_stat_data  <= '0;
            r_pend       <= 1'b0;
            r_pend_left  <= '0;
            r_pend_right <= '0;
            rec_overrun  <= 1'b0;
        end else begin
            if (cmd_valid && cmd_rd) begin
                r_stat_valid <= 1'b1;
                r_stat_addr  <= cmd_addr;
                r_stat_data  <= reg_rd_data;
            end else if (w_sync_rise) begin
                r_stat_valid <= 1'b0;
            end
            // A capture arriving on bit 0 rides in that frame instead of pending
            rec_overrun <= rec_valid && r_pend && !w_sync_rise;
            if (w_sync_rise) begin
                r_pend <= 1'b0;
            end else if (rec_valid) begin
                r_pend       <= 1'b1;
                r_pend_left  <= rec_left;
                r_pend_right <= rec_right;
            end
        end
    end

    always_comb begin
        w_tx            = '0;
        w_tx.ready      = codec_ready;
        w_tx.stat_valid = r_stat_valid;
        w_tx.stat_addr  = r_stat_addr;
        w_tx.stat_data  = r_stat_data;
        w_tx.cap_valid  = r_pend || rec_valid;
        w_tx.cap_left   = rec_valid ? rec_left  : r_pend_left;
        w_tx.cap_right  = rec_valid ? rec_right : r_pend_right;
    end

    ac97_slot_ser u_slot_ser (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_sync_rise),
        .i_active  (r_state == FRAME),
        .i_content (w_tx),
        .o_sdata   (AC97_SDATA_IN)
    );

endmodule

`default_nettype wire

// File: tb/tb_ac97_codec_link.sv
//------------------------------------------------------------------------------
// Module      : tb_ac97_codec_link
// Description : Directed frame-level bench for the codec-side AC-link engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ac97_codec_link;
    import ac97_pkg::*;

    logic        clk = 1'b0;
    logic        rst, sync, sdo, sdi, codec_ready;
    logic        cmd_valid, cmd_rd, play_valid, rec_valid, rec_overrun, resync_err;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data, reg_rd_data, play_left, play_right, rec_left, rec_right;

    always #5 clk = ~clk;

    ac97_codec_link dut (
        .clk(clk), .rst(rst), .AC97_SYNC(sync), .AC97_SDATA_OUT(sdo), .AC97_SDATA_IN(sdi),
        .codec_ready(codec_ready), .cmd_valid(cmd_valid), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .reg_rd_data(reg_rd_data),
        .play_valid(play_valid), .play_left(play_left), .play_right(play_right),
        .rec_valid(rec_valid), .rec_left(rec_left), .rec_right(rec_right),
        .rec_overrun(rec_overrun), .resync_err(resync_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Per-frame observations
    int           cmd_cnt, cmd_cyc, play_cnt, play_cyc, ovr_cnt, rse_cnt;
    logic         cmd_rd_s;
    logic [6:0]   cmd_addr_s;
    logic [15:0]  cmd_data_s;
    logic [255:0] got;
    int           rec_at [2];
    logic [15:0]  rec_l [2];
    logic [15:0]  rec_r [2];

    function automatic logic [255:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                        input logic [19:0] s2, input logic [19:0] s3,
                                        input logic [19:0] s4);
        return {tag, s1, s2, s3, s4, 160'h0};
    endfunction

    task automatic send_frame(input logic [255:0] f, input int n_bits);
        cmd_cnt = 0; play_cnt = 0; ovr_cnt = 0; rse_cnt = 0; got = '0;
        cmd_cyc = -1; play_cyc = -1;
        for (int k = 0; k < n_bits; k++) begin
            @(negedge clk);
            sync      = (k < TAG_BITS);
            sdo       = f[FRAME_BITS-1-k];
            rec_valid = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (rec_at[j] == k) begin
                    rec_valid = 1'b1;
                    rec_left  = rec_l[j];
                    rec_right = rec_r[j];
                end
            end
            if (k > 0) got[FRAME_BITS-k] = sdi;
            if (cmd_valid) begin
                cmd_cnt++; cmd_cyc = k;
                cmd_rd_s = cmd_rd; cmd_addr_s = cmd_addr; cmd_data_s = cmd_data;
            end
            if (play_valid) begin play_cnt++; play_cyc = k; end
            if (rec_overrun) ovr_cnt++;
            if (resync_err) rse_cnt++;
        end
    endtask

    task automatic idle_cycles(input int n, output int busy);
        busy = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sync = 1'b0; sdo = 1'b0; rec_valid = 1'b0;
            if (sdi || cmd_valid || play_valid || rec_overrun || resync_err) busy++;
        end
    endtask

    task automatic check_resp(input string p, input logic [15:0] tag, input logic [19:0] s1,
                              input logic [19:0] s2, input logic [19:0] s3, input logic [19:0] s4);
        check({p, "_tag"}, got[255:240], tag);
        check({p, "_s1"},  got[239:220], s1);
        check({p, "_s2"},  got[219:200], s2);
        check({p, "_s3"},  got[199:180], s3);
        check({p, "_s4"},  got[179:160], s4);
        check({p, "_tail_zero"}, |got[159:1], 1'b0);
    endtask

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
        logic        cr;
        logic [15:0] rd_data;
        logic        exp_cmd, exp_rd;
        logic [6:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_play;
        logic [15:0] exp_left, exp_right;
        logic [15:0] exp_tag;
        logic [19:0] exp_s1, exp_s2;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        int busy;
        vecs[0] = '{16'hE000, 20'hA6000, 20'h0,     20'h0,     20'h0,     1'b1, 16'h000F,
                    1'b1, 1'b1, 7'h26, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h8000, 20'h0, 20'h0};
        vecs[1] = '{16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 1'b1, 16'h0000,
                    1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 16'h1234, 16'hABCD, 16'hE000, 20'h26000, 20'h000F0};
        vecs[2] = '{16'hE000, 20'h02000, 20'h80000, 20'h0,     20'h0,     1'b1, 16'h0000,
                    1'b1, 1'b0, 7'h02, 16'h8000, 1'b0, 16'h1234, 16'hABCD, 16'h8000, 20'h0, 20'h0};
        vecs[3] = '{16'hC000, 20'h05000, 20'hABCD0, 20'h0,     20'h0,     1'b1, 16'h0000,
                    1'b1, 1'b0, 7'h05, 16'h0000, 1'b0, 16'h1234, 16'hABCD, 16'h8000, 20'h0, 20'h0};
        vecs[4] = '{16'hC000, 20'hFF000, 20'h0,     20'h0,     20'h0,     1'b1, 16'hBEEF,
                    1'b1, 1'b1, 7'h7F, 16'h0000, 1'b0, 16'h1234, 16'hABCD, 16'h8000, 20'h0, 20'h0};
        vecs[5] = '{16'h9000, 20'hA6000, 20'h0,     20'h11111, 20'h22222, 1'b1, 16'h0000,
                    1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 16'h1234, 16'hABCD, 16'hE000, 20'h7F000, 20'hBEEF0};
        vecs[6] = '{16'h7800, 20'hA6000, 20'h0,     20'h55555, 20'h66666, 1'b0, 16'h0000,
                    1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 16'h5555, 16'h6666, 16'h0000, 20'h0, 20'h0};

        rst = 1'b1; sync = 1'b1; sdo = 1'b0; codec_ready = 1'b1; reg_rd_data = '0;
        rec_valid = 1'b0; rec_left = '0; rec_right = '0;
        rec_at[0] = -1; rec_at[1] = -1; rec_l[0] = '0; rec_l[1] = '0; rec_r[0] = '0; rec_r[1] = '0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {sdi, cmd_valid, cmd_rd, cmd_addr, cmd_data, play_valid,
                                play_left, play_right, rec_overrun, resync_err}, 64'h0);
        rst = 1'b0;

        // SYNC still high at release: must not start a frame
        busy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (sdi || resync_err) busy++;
        end
        check("sync_high_at_release_no_frame", busy, 0);
        check("sync_high_at_release_idle", dut.r_state, IDLE);
        idle_cycles(2, busy);

        for (int i = 0; i < 7; i++) begin
            codec_ready = vecs[i].cr;
            reg_rd_data = vecs[i].rd_data;
            send_frame(mk(vecs[i].tag, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4), FRAME_BITS);
            check($sformatf("v%0d_cmd_cnt", i), cmd_cnt, int'(vecs[i].exp_cmd));
            if (vecs[i].exp_cmd) begin
                check($sformatf("v%0d_cmd_cycle", i), cmd_cyc, 56);
                check($sformatf("v%0d_cmd_rd", i), cmd_rd_s, vecs[i].exp_rd);
                check($sformatf("v%0d_cmd_addr", i), cmd_addr_s, vecs[i].exp_addr);
                check($sformatf("v%0d_cmd_data", i), cmd_data_s, vecs[i].exp_data);
            end
            check($sformatf("v%0d_play_cnt", i), play_cnt, int'(vecs[i].exp_play));
            if (vecs[i].exp_play) check($sformatf("v%0d_play_cycle", i), play_cyc, 96);
            check($sformatf("v%0d_play_left", i), play_left, vecs[i].exp_left);
            check($sformatf("v%0d_play_right", i), play_right, vecs[i].exp_right);
            check($sformatf("v%0d_no_resync", i), rse_cnt, 0);
            check_resp($sformatf("v%0d_resp", i), vecs[i].exp_tag, vecs[i].exp_s1, vecs[i].exp_s2, 20'h0, 20'h0);
        end

        // Capture overrun, then a capture landing on bit 0
        codec_ready = 1'b1;
        rec_at[0] = 10; rec_l[0] = 16'h1111; rec_r[0] = 16'h2222;
        rec_at[1] = 20; rec_l[1] = 16'h3333; rec_r[1] = 16'h4444;
        send_frame(mk(16'h8000, 0, 0, 0, 0), FRAME_BITS);
        check("cap_overrun_once", ovr_cnt, 1);
        check_resp("cap_f1", 16'h8000, 0, 0, 0, 0);
        rec_at[0] = -1; rec_at[1] = -1;
        send_frame(mk(16'h8000, 0, 0, 0, 0), FRAME_BITS);
        check_resp("cap_f2", 16'h9800, 0, 0, 20'h33330, 20'h44440);
        check("cap_f2_no_overrun", ovr_cnt, 0);
        rec_at[0] = 200; rec_l[0] = 16'h5555; rec_r[0] = 16'h6666;
        send_frame(mk(16'h8000, 0, 0, 0, 0), FRAME_BITS);
        check_resp("cap_f3", 16'h8000, 0, 0, 0, 0);
        rec_at[0] = 0; rec_l[0] = 16'h7777; rec_r[0] = 16'h8888;
        send_frame(mk(16'h8000, 0, 0, 0, 0), FRAME_BITS);
        check_resp("cap_bit0", 16'h9800, 0, 0, 20'h77770, 20'h88880);
        check("cap_bit0_no_overrun", ovr_cnt, 0);
        rec_at[0] = -1;
        send_frame(mk(16'h8000, 0, 0, 0, 0), FRAME_BITS);
        check_resp("cap_f5", 16'h8000, 0, 0, 0, 0);

        // Resync: SYNC re-rises at cycle 40 of a read frame
        reg_rd_data = 16'h000F;
        send_frame(mk(16'hE000, 20'hA6000, 0, 0, 0), 40);
        check("resync_aborted_no_cmd", cmd_cnt, 0);
        send_frame(mk(16'h9800, 0, 0, 20'h12345, 20'hABCDE), FRAME_BITS);
        check("resync_err_once", rse_cnt, 1);
        check("resync_new_no_cmd", cmd_cnt, 0);
        check("resync_play_cnt", play_cnt, 1);
        check("resync_play_cycle", play_cyc, 96);
        check("resync_play_left", play_left, 16'h1234);
        check("resync_play_right", play_right, 16'hABCD);
        check_resp("resync_resp", 16'h8000, 0, 0, 0, 0);

        // Reset at cycle 100 of a read frame
        send_frame(mk(16'hE000, 20'hA6000, 0, 0, 0), 100);
        check("rstmid_cmd_seen", cmd_cnt, 1);
        @(negedge clk);
        rst = 1'b1; sync = 1'b0; sdo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_outputs_zero", {sdi, cmd_valid, cmd_rd, cmd_addr, cmd_data, play_valid,
                                     play_left, play_right, rec_overrun, resync_err}, 64'h0);
        idle_cycles(300, busy);
        check("rstmid_idle_quiet", busy, 0);
        check("rstmid_state_idle", dut.r_state, IDLE);

        // Write command, then frame end with no SYNC
        send_frame(mk(16'hE000, 20'h02000, 20'h80000, 0, 0), FRAME_BITS);
        check("wr_cmd_cnt", cmd_cnt, 1);
        check("wr_cmd_rd", cmd_rd_s, 1'b0);
        check("wr_cmd_addr", cmd_addr_s, 7'h02);
        check("wr_cmd_data", cmd_data_s, 16'h8000);
        check("wr_no_resync_after_reset", rse_cnt, 0);
        check_resp("wr_resp", 16'h8000, 0, 0, 0, 0);
        idle_cycles(260, busy);
        check("end_idle_quiet", busy, 0);
        check("end_state_idle", dut.r_state, IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
